// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall/flush
//                scheduler: multi-cycle sequencer state encoding and the
//                bit positions of the per-stage stall/flush vectors.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Multi-cycle unit sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_RUN  = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // Stage indices used in the internal stall/flush vectors
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_stall_ctrl
//  Description : Central stall/flush scheduler for the 5-stage core. Merges
//                hazard-unit requests, data/instruction memory wait states and
//                an iterative multi-cycle execute op into one per-stage
//                stall/flush set, and sequences the multi-cycle unit.
//  Ports       :
//    clk, rst                 clock, synchronous active-high reset
//    LoadUseStall             load-use hazard detected
//    PCSrcE                   taken branch/jump resolved in Execute
//    McStartE                 Execute holds a multi-cycle op
//    IMemReady                instruction fetch completes this cycle
//    DMemReqM, DMemReady      data memory request / completion in Memory
//    StallF/D/E/M             hold PC / IFID / IDEX / EXMEM
//    FlushD/E/M               bubble into IFID / IDEX / EXMEM
//    McGo                     one-cycle start pulse to multi-cycle unit
//    McCapture                multi-cycle result valid, Execute advances
//    McBusy                   sequencer not idle
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic LoadUseStall,
    input  logic PCSrcE,
    input  logic McStartE,
    input  logic IMemReady,
    input  logic DMemReqM,
    input  logic DMemReady,
    output logic StallF,
    output logic StallD,
    output logic StallE,
    output logic StallM,
    output logic FlushD,
    output logic FlushE,
    output logic FlushM,
    output logic McGo,
    output logic McCapture,
    output logic McBusy
);

    localparam int CNT_W = $clog2(MC_LATENCY + 1);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MC_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mc_state_t        r_state;
    mc_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_dfreeze;
    logic             w_mcstall;
    logic             w_go;
    logic             w_cap;
    logic [3:0]       w_stall;
    logic [3:1]       w_flush;

    // A pending data access freezes the whole back end, sequencer included.
    assign w_dfreeze = DMemReqM & ~DMemReady;
    // The op itself is stalled in Execute from its first cycle until MC_DONE.
    assign w_mcstall = ((r_state == IDLE) & McStartE) | (r_state == MC_RUN);

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go        = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (McStartE && !w_dfreeze) begin
                    w_go        = 1'b1;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = (MC_LATENCY == 1) ? MC_DONE : MC_RUN;
                end
            end
            MC_RUN: begin
                if (!w_dfreeze) begin
                    // Guarded decrement: the counter can never wrap.
                    if (r_cnt >= c_CNT_ONE) begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                    if (r_cnt == c_CNT_ONE) begin
                        w_state_nxt = MC_DONE;
                    end
                end
            end
            MC_DONE: begin
                // Result stays valid while the back end is frozen.
                w_cap = 1'b1;
                if (!w_dfreeze) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Priority stall/flush resolution (first match wins)
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (w_dfreeze) begin
            w_stall = 4'b1111;
        end else if (w_mcstall) begin
            w_stall[STG_F] = 1'b1;
            w_stall[STG_D] = 1'b1;
            w_stall[STG_E] = 1'b1;
            w_flush[STG_M] = 1'b1;
        end else if (PCSrcE) begin
            w_flush[STG_D] = 1'b1;
            w_flush[STG_E] = 1'b1;
        end else if (LoadUseStall) begin
            w_stall[STG_F] = 1'b1;
            w_stall[STG_D] = 1'b1;
            w_flush[STG_E] = 1'b1;
        end else if (!IMemReady) begin
            w_stall[STG_F] = 1'b1;
            w_flush[STG_D] = 1'b1;
        end
    end

    // Outputs are forced quiet for the whole reset period, even before the
    // state register has been initialised.
    always_comb begin
        if (rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
            McGo      = 1'b0;
            McCapture = 1'b0;
            McBusy    = 1'b0;
        end else begin
            StallF    = w_stall[STG_F];
            StallD    = w_stall[STG_D];
            StallE    = w_stall[STG_E];
            StallM    = w_stall[STG_M];
            FlushD    = w_flush[STG_D];
            FlushE    = w_flush[STG_E];
            FlushM    = w_flush[STG_M];
            McGo      = w_go;
            McCapture = w_cap;
            McBusy    = (r_state != IDLE);
        end
    end

endmodule : pipeline_stall_ctrl
`default_nettype wire
